uc_varredura_colisoes: RTL



---
 rtl/uc_varredura_colisoes_pkg.sv | 24 ++
 rtl/uc_varredura_colisoes_contador.sv | 33 +++
 rtl/uc_varredura_colisoes.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uc_varredura_colisoes_pkg.sv
// Shared definitions for the collision-scan control unit: slot-count defaults
// and the FSM state codes (also reported on db_estado).
package uc_varredura_colisoes_pkg;

  localparam int unsigned N_TIROS_PADRAO      = 4;
  localparam int unsigned N_ASTEROIDES_PADRAO = 8;
  localparam int unsigned W_TIRO_PADRAO       = 2;
  localparam int unsigned W_AST_PADRAO        = 3;

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    ZERA          = 4'h1,
    LE_TIRO       = 4'h2,
    COMPARA_TIRO  = 4'h3,
    REGISTRA_TIRO = 4'h4,
    AVANCA_TIRO   = 4'h5,
    LE_NAVE       = 4'h6,
    COMPARA_NAVE  = 4'h7,
    REGISTRA_NAVE = 4'h8,
    FIM           = 4'h9,
    ERRO          = 4'hF
  } estado_t;

endpackage

// File: rtl/uc_varredura_colisoes_contador.sv
// Loadable up-counter for a scan index; rco flags the terminal slot so the
// FSM never relies on wrap-around.
module uc_varredura_colisoes_contador
  import uc_varredura_colisoes_pkg::*;
#(
  parameter int unsigned W   = W_TIRO_PADRAO,
  parameter int unsigned FIM = N_TIROS_PADRAO - 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] dado,
  input  logic         enable,
  output logic [W-1:0] q,
  output logic         rco
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock) begin
    if (reset || clear)
      r_q <= '0;
    else if (load)
      r_q <= dado;
    else if (enable)
      r_q <= r_q + W'(1);
  end

  assign q   = r_q;
  assign rco = (r_q == W'(FIM));

endmodule

// File: rtl/uc_varredura_colisoes.sv
// Collision-scan control unit: every shot against every asteroid, then every
// asteroid against the ship, issuing deactivate/score/life pulses.
module uc_varredura_colisoes
  import uc_varredura_colisoes_pkg::*;
#(
  parameter int unsigned N_TIROS      = N_TIROS_PADRAO,
  parameter int unsigned N_ASTEROIDES = N_ASTEROIDES_PADRAO,
  parameter int unsigned W_TIRO       = W_TIRO_PADRAO,
  parameter int unsigned W_AST        = W_AST_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              tiro_ativo,
  input  logic              asteroide_ativo,
  input  logic              colisao_tiro,
  input  logic              colisao_nave,
  output logic [W_TIRO-1:0] endereco_tiro,
  output logic [W_AST-1:0]  endereco_asteroide,
  output logic              desativa_tiro,
  output logic              desativa_asteroide,
  output logic              incrementa_pontuacao,
  output logic              decrementa_vidas,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  estado_t           r_estado, w_prox;
  logic [W_TIRO-1:0] w_idx_t;
  logic [W_AST-1:0]  w_idx_a;
  logic              w_rco_t, w_rco_a;
  logic              w_clr_t, w_clr_a, w_en_t, w_en_a;

  uc_varredura_colisoes_contador #(.W(W_TIRO), .FIM(N_TIROS - 1)) u_idx_t (
    .clock(clock), .reset(reset), .clear(w_clr_t), .load(1'b0), .dado('0),
    .enable(w_en_t), .q(w_idx_t), .rco(w_rco_t)
  );

  uc_varredura_colisoes_contador #(.W(W_AST), .FIM(N_ASTEROIDES - 1)) u_idx_a (
    .clock(clock), .reset(reset), .clear(w_clr_a), .load(1'b0), .dado('0),
    .enable(w_en_a), .q(w_idx_a), .rco(w_rco_a)
  );

  always_ff @(posedge clock) begin
    if (reset)
      r_estado <= INICIAL;
    else
      r_estado <= w_prox;
  end

  always_comb begin
    w_prox               = r_estado;
    w_clr_t              = 1'b0;
    w_clr_a              = 1'b0;
    w_en_t               = 1'b0;
    w_en_a               = 1'b0;
    desativa_tiro        = 1'b0;
    desativa_asteroide   = 1'b0;
    incrementa_pontuacao = 1'b0;
    decrementa_vidas     = 1'b0;
    ocupado              = 1'b1;
    pronto               = 1'b0;
    case (r_estado)
      INICIAL: begin
        ocupado = 1'b0;
        if (iniciar) w_prox = ZERA;
      end
      ZERA: begin
        w_clr_t = 1'b1;
        w_clr_a = 1'b1;
        w_prox  = LE_TIRO;
      end
      LE_TIRO: w_prox = COMPARA_TIRO;
      COMPARA_TIRO: begin
        if (!tiro_ativo)
          w_prox = AVANCA_TIRO;
        else if (asteroide_ativo && colisao_tiro)
          w_prox = REGISTRA_TIRO;
        else if (w_rco_a)
          w_prox = AVANCA_TIRO;
        else begin
          w_en_a = 1'b1;
          w_prox = LE_TIRO;
        end
      end
      REGISTRA_TIRO: begin
        desativa_tiro        = 1'b1;
        desativa_asteroide   = 1'b1;
        incrementa_pontuacao = 1'b1;
        w_prox               = AVANCA_TIRO;
      end
      AVANCA_TIRO: begin
        w_clr_a = 1'b1;
        if (w_rco_t)
          w_prox = LE_NAVE;
        else begin
          w_en_t = 1'b1;
          w_prox = LE_TIRO;
        end
      end
      LE_NAVE: w_prox = COMPARA_NAVE;
      COMPARA_NAVE: begin
        if (asteroide_ativo && colisao_nave)
          w_prox = REGISTRA_NAVE;
        else if (w_rco_a)
          w_prox = FIM;
        else begin
          w_en_a = 1'b1;
          w_prox = LE_NAVE;
        end
      end
      REGISTRA_NAVE: begin
        desativa_asteroide = 1'b1;
        decrementa_vidas   = 1'b1;
        if (w_rco_a)
          w_prox = FIM;
        else begin
          w_en_a = 1'b1;
          w_prox = LE_NAVE;
        end
      end
      FIM: begin
        pronto  = 1'b1;
        w_clr_t = 1'b1;
        w_clr_a = 1'b1;
        w_prox  = INICIAL;
      end
      ERRO:    w_prox = ERRO;
      default: w_prox = ERRO;
    endcase
  end

  assign endereco_tiro      = w_idx_t;
  assign endereco_asteroide = w_idx_a;
  assign db_estado          = 4'(r_estado);

endmodule
